// File: rtl/uart_apb_sequencer.sv
// APB requester for the UART register block: programs it on cfg_start, then
// round-robins between pushing TX stream bytes and popping RX bytes.
module uart_apb_sequencer #(
  parameter logic [31:0] BASE_ADDR     = 32'h0,
  parameter int unsigned TX_FIFO_DEPTH = 16,
  parameter int unsigned POLL_INTERVAL = 8
) (
  input  logic        clk_i,
  input  logic        arst_ni,
  input  logic        cfg_start_i,
  input  logic [31:0] cfg_clk_div_i,
  input  logic        cfg_parity_en_i,
  input  logic        cfg_parity_type_i,
  input  logic        cfg_stop_bits_i,
  input  logic        cfg_rx_int_en_i,
  output logic        cfg_done_o,
  output logic        busy_o,
  output logic        err_o,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  output logic [3:0]  pstrb_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);
  // state   | meaning
  // IDLE    | reset, or parked while a restart waits for the bus
  // C0..C3  | config writes: CLK_DIV, CONFIG, CTRL=7, CTRL=1
  // ARB     | service loop, picks TX or RX
  // TX_STAT | reading TX FIFO status
  // TX_WR   | writing the TX byte
  // RX_STAT | reading RX FIFO status
  // RX_DATA | popping the RX byte
  // ERR     | PSLVERR seen, bus quiet until cfg_start
  typedef enum logic [3:0] {
    S_IDLE, S_C0, S_C1, S_C2, S_C3, S_ARB,
    S_TX_STAT, S_TX_WR, S_RX_STAT, S_RX_DATA, S_ERR
  } state_t;

  localparam logic [31:0] OFF_CTRL    = 32'h00;
  localparam logic [31:0] OFF_CONFIG  = 32'h04;
  localparam logic [31:0] OFF_CLK_DIV = 32'h08;
  localparam logic [31:0] OFF_TX_STAT = 32'h0C;
  localparam logic [31:0] OFF_RX_STAT = 32'h10;
  localparam logic [31:0] OFF_TX_DATA = 32'h14;
  localparam logic [31:0] OFF_RX_DATA = 32'h18;
  localparam logic [31:0] DEPTH       = 32'(TX_FIFO_DEPTH);
  localparam logic [7:0]  POLL_RELOAD = 8'(POLL_INTERVAL);

  state_t      state, state_d;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        cfg_pend, cfg_done, err, prio_rx, rx_valid;
  logic [31:0] cfg_div;
  logic [3:0]  cfg_bits;
  logic [7:0]  poll_cnt, rx_data;

  logic        launch, done, accept, pend_now;
  logic [31:0] nxt_addr, nxt_wdata;
  logic        nxt_write;
  logic        grant_tx, grant_rx, poll_reload, poll_dec, rx_latch;
  logic        tx_req, rx_req;

  assign done     = psel && penable && pready_i;
  assign pend_now = cfg_start_i || cfg_pend;
  assign accept   = !psel && pend_now;
  assign tx_req   = tx_valid_i;
  assign rx_req   = !rx_valid && (poll_cnt == 8'd0);

  always_comb begin
    state_d     = state;
    launch      = 1'b0;
    nxt_addr    = BASE_ADDR;
    nxt_write   = 1'b0;
    nxt_wdata   = '0;
    grant_tx    = 1'b0;
    grant_rx    = 1'b0;
    poll_reload = 1'b0;
    poll_dec    = 1'b0;
    rx_latch    = 1'b0;
    if (accept) begin
      // the same-cycle pulse is not yet captured, so take its divider directly
      state_d   = S_C0;
      launch    = 1'b1;
      nxt_addr  = BASE_ADDR + OFF_CLK_DIV;
      nxt_write = 1'b1;
      nxt_wdata = cfg_start_i ? cfg_clk_div_i : cfg_div;
    end else if (done && pslverr_i) begin
      state_d = S_ERR;
    end else if (done && pend_now) begin
      state_d = S_IDLE;
    end else begin
      unique case (state)
        S_C0: if (done) begin
          state_d = S_C1; launch = 1'b1; nxt_write = 1'b1;
          nxt_addr = BASE_ADDR + OFF_CONFIG; nxt_wdata = {28'b0, cfg_bits};
        end
        S_C1: if (done) begin
          state_d = S_C2; launch = 1'b1; nxt_write = 1'b1;
          nxt_addr = BASE_ADDR + OFF_CTRL; nxt_wdata = 32'h0000_0007;
        end
        S_C2: if (done) begin
          state_d = S_C3; launch = 1'b1; nxt_write = 1'b1;
          nxt_addr = BASE_ADDR + OFF_CTRL; nxt_wdata = 32'h0000_0001;
        end
        S_C3: if (done) state_d = S_ARB;
        S_ARB: begin
          if (tx_req && (!rx_req || !prio_rx)) begin
            grant_tx = 1'b1; launch = 1'b1; state_d = S_TX_STAT;
            nxt_addr = BASE_ADDR + OFF_TX_STAT;
          end else if (rx_req) begin
            grant_rx = 1'b1; launch = 1'b1; state_d = S_RX_STAT;
            nxt_addr = BASE_ADDR + OFF_RX_STAT;
          end else begin
            poll_dec = 1'b1;
          end
        end
        S_TX_STAT: if (done) begin
          if ((prdata_i < DEPTH) && tx_valid_i) begin
            state_d = S_TX_WR; launch = 1'b1; nxt_write = 1'b1;
            nxt_addr = BASE_ADDR + OFF_TX_DATA; nxt_wdata = {24'b0, tx_data_i};
          end else begin
            state_d = S_ARB;
          end
        end
        S_TX_WR: if (done) state_d = S_ARB;
        S_RX_STAT: if (done) begin
          if (prdata_i == 32'd0) begin
            poll_reload = 1'b1; state_d = S_ARB;
          end else begin
            state_d = S_RX_DATA; launch = 1'b1;
            nxt_addr = BASE_ADDR + OFF_RX_DATA;
          end
        end
        S_RX_DATA: if (done) begin
          rx_latch = 1'b1; state_d = S_ARB;
        end
        default: state_d = state;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) state <= S_IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      psel <= 1'b0; penable <= 1'b0; pwrite <= 1'b0;
      paddr <= '0; pwdata <= '0;
    end else if (launch) begin
      psel <= 1'b1; penable <= 1'b0; pwrite <= nxt_write;
      paddr <= nxt_addr; pwdata <= nxt_wdata;
    end else if (psel && !penable) begin
      penable <= 1'b1;
    end else if (done) begin
      psel <= 1'b0; penable <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cfg_pend <= 1'b0; cfg_div <= '0; cfg_bits <= '0; cfg_done <= 1'b0;
      err <= 1'b0; prio_rx <= 1'b0; poll_cnt <= '0;
      rx_valid <= 1'b0; rx_data <= '0;
    end else begin
      if (cfg_start_i) begin
        cfg_div  <= cfg_clk_div_i;
        cfg_bits <= {cfg_rx_int_en_i, cfg_stop_bits_i, cfg_parity_type_i, cfg_parity_en_i};
      end
      if (accept)           cfg_pend <= 1'b0;
      else if (cfg_start_i) cfg_pend <= 1'b1;

      if (cfg_start_i || state_d == S_ERR)      cfg_done <= 1'b0;
      else if (state == S_C3 && state_d == S_ARB) cfg_done <= 1'b1;

      if (accept)                 err <= 1'b0;
      else if (done && pslverr_i) err <= 1'b1;

      if (grant_tx)      prio_rx <= 1'b1;
      else if (grant_rx) prio_rx <= 1'b0;

      if (accept)                              poll_cnt <= '0;
      else if (poll_reload)                    poll_cnt <= POLL_RELOAD;
      else if (poll_dec && poll_cnt != 8'd0)   poll_cnt <= poll_cnt - 8'd1;

      if (accept) begin
        rx_valid <= 1'b0; rx_data <= '0;
      end else if (rx_latch) begin
        rx_valid <= 1'b1; rx_data <= prdata_i[7:0];
      end else if (rx_valid && rx_ready_i) begin
        rx_valid <= 1'b0; rx_data <= '0;
      end
    end
  end

  assign cfg_done_o = cfg_done;
  assign busy_o     = psel;
  assign err_o      = err;
  assign tx_ready_o = (state == S_TX_WR) && done && !pslverr_i;
  assign rx_data_o  = rx_data;
  assign rx_valid_o = rx_valid;
  assign paddr_o    = paddr;
  assign psel_o     = psel;
  assign penable_o  = penable;
  assign pwrite_o   = pwrite;
  assign pwdata_o   = pwdata;
  assign pstrb_o    = pwrite ? 4'hF : 4'h0;

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Directed bench for uart_apb_sequencer: a small APB slave model with
// programmable status/data/wait/error, plus a transfer log for checking.
module tb_uart_apb_sequencer;
  logic        clk = 1'b0;
  logic        arst_n;
  logic        cfg_start, cfg_parity_en, cfg_parity_type, cfg_stop_bits, cfg_rx_int_en;
  logic [31:0] cfg_clk_div;
  logic        cfg_done, busy, err;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;

  uart_apb_sequencer dut (
    .clk_i(clk), .arst_ni(arst_n),
    .cfg_start_i(cfg_start), .cfg_clk_div_i(cfg_clk_div),
    .cfg_parity_en_i(cfg_parity_en), .cfg_parity_type_i(cfg_parity_type),
    .cfg_stop_bits_i(cfg_stop_bits), .cfg_rx_int_en_i(cfg_rx_int_en),
    .cfg_done_o(cfg_done), .busy_o(busy), .err_o(err),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .prdata_i(prdata),
    .pready_i(pready), .pslverr_i(pslverr)
  );

  always #5 clk = ~clk;

  // slave model
  int          wait_cycles = 0;
  int          wcnt = 0;
  logic [31:0] tx_tab [4];
  logic [7:0]  rx_tab [2];
  logic [31:0] rx_stat = 32'd0;
  int          tx_idx = 0, rx_idx = 0;
  logic        err_en = 1'b0;

  assign pready  = psel && penable && (wcnt >= wait_cycles);
  assign pslverr = err_en && (paddr == 32'h14);

  always_comb begin
    prdata = 32'd0;
    case (paddr)
      32'h0C:  prdata = tx_tab[tx_idx];
      32'h10:  prdata = rx_stat;
      32'h18:  prdata = {24'h0, rx_tab[rx_idx]};
      default: prdata = 32'd0;
    endcase
  end

  // transfer log and protocol monitor
  int          cyc = 0;
  logic [31:0] lg_addr[$], lg_data[$];
  logic        lg_wr[$];
  logic [3:0]  lg_strb[$];
  int          lg_cyc[$], lg_start[$], lg_len[$];
  logic [31:0] s_addr, s_data;
  logic        s_wr;
  int          s_start = 0, acc_len = 0, stab_err = 0, tx_rdy_cnt = 0;
  int          n_tests = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (psel && penable && !pready) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
    if (tx_ready) tx_rdy_cnt++;
    if (psel && !penable) begin
      s_addr = paddr; s_data = pwdata; s_wr = pwrite; s_start = cyc; acc_len = 0;
    end else if (psel && penable) begin
      acc_len++;
      if (paddr !== s_addr || pwdata !== s_data || pwrite !== s_wr) stab_err++;
      if (pready) begin
        lg_addr.push_back(paddr);
        lg_data.push_back(pwrite ? pwdata : prdata);
        lg_wr.push_back(pwrite);
        lg_strb.push_back(pstrb);
        lg_cyc.push_back(cyc);
        lg_start.push_back(s_start);
        lg_len.push_back(acc_len);
        if (!pwrite && paddr == 32'h0C && tx_idx < 3) tx_idx++;
        if (!pwrite && paddr == 32'h18 && rx_idx < 1) rx_idx++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    lg_addr.delete(); lg_data.delete(); lg_wr.delete(); lg_strb.delete();
    lg_cyc.delete(); lg_start.delete(); lg_len.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int count_addr(input logic [31:0] a);
    int n = 0;
    foreach (lg_addr[i]) if (lg_addr[i] == a) n++;
    return n;
  endfunction

  function automatic int find_addr(input logic [31:0] a);
    foreach (lg_addr[i]) if (lg_addr[i] == a) return i;
    return -1;
  endfunction

  task automatic start_cfg(input logic [31:0] div, input logic [3:0] bits);
    cfg_clk_div = div;
    {cfg_rx_int_en, cfg_stop_bits, cfg_parity_type, cfg_parity_en} = bits;
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
  endtask

  task automatic wait_cfg_done(output int done_cyc);
    for (int i = 0; i < 100 && !cfg_done; i++) @(negedge clk);
    done_cyc = cyc;
  endtask

  task automatic check_cfg_log(input string tag, input logic [31:0] div, input logic [31:0] cfg);
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    ea = '{32'h08, 32'h04, 32'h00, 32'h00};
    ed = '{div, cfg, 32'h7, 32'h1};
    chk({tag, "_nxfer"}, lg_addr.size(), 4);
    for (int i = 0; i < 4 && i < lg_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), lg_addr[i], ea[i]);
      chk($sformatf("%s_data%0d", tag, i), lg_data[i], ed[i]);
      chk($sformatf("%s_wr_strb%0d", tag, i), {27'd0, lg_wr[i], lg_strb[i]}, 32'h1F);
    end
  endtask

  initial begin
    int done_cyc, w, n0c, hold, k, gap, snap, nps, i10a, i10b;
    logic [31:0] alt [8];
    tx_tab = '{32'd0, 32'd0, 32'd0, 32'd0};
    rx_tab = '{8'h00, 8'h00};
    arst_n = 1'b0; cfg_start = 1'b0; cfg_clk_div = '0;
    cfg_parity_en = 0; cfg_parity_type = 0; cfg_stop_bits = 0; cfg_rx_int_en = 0;
    tx_data = '0; tx_valid = 0; rx_ready = 0;

    // reset state
    tick(3);
    chk("rst_psel_penable", {psel, penable}, 0);
    chk("rst_busy_done_err", {busy, cfg_done, err}, 0);
    chk("rst_txrdy_rxvalid", {tx_ready, rx_valid}, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata_pstrb", {pwdata, pstrb}, 0);
    arst_n = 1'b1;
    tick(2);
    chk("idle_no_traffic", lg_addr.size(), 0);

    // configuration sequence
    clr_log();
    start_cfg(32'h1B2, 4'b0101);
    @(negedge clk);
    chk("cfg_busy_after_start", {busy, cfg_done}, 2'b10);
    wait_cfg_done(done_cyc);
    chk("cfg_done_set", cfg_done, 1);
    check_cfg_log("cfg1", 32'h1B2, 32'h5);
    if (lg_cyc.size() >= 4) chk("cfg_done_timing", done_cyc, lg_cyc[3] + 1);

    // TX with status 3 and a 3-cycle pready delay
    tick(1);
    wait_cycles = 3;
    tx_tab = '{32'd3, 32'd3, 32'd3, 32'd3}; tx_idx = 0;
    clr_log(); snap = tx_rdy_cnt; stab_err = 0;
    tx_data = 8'hA5; tx_valid = 1'b1;
    for (int i = 0; i < 200 && !tx_ready; i++) @(negedge clk);
    tick(1); tx_valid = 1'b0;
    tick(5);
    chk("tx1_ready_pulses", tx_rdy_cnt - snap, 1);
    chk("tx1_nwrites", count_addr(32'h14), 1);
    w = find_addr(32'h14);
    if (w > 0) begin
      chk("tx1_wr_data", lg_data[w], 32'hA5);
      chk("tx1_wr_strb", {lg_wr[w], lg_strb[w]}, 5'h1F);
      chk("tx1_access_len", lg_len[w], 4);
      chk("tx1_prev_stat_read", {lg_addr[w-1], 31'd0, lg_wr[w-1]}, {32'h0C, 32'd0});
    end
    chk("tx1_stable", stab_err, 0);

    // TX FIFO full twice, then space
    wait_cycles = 0;
    tx_tab = '{32'd16, 32'd16, 32'd15, 32'd15}; tx_idx = 0;
    clr_log(); snap = tx_rdy_cnt;
    tx_data = 8'h5A; tx_valid = 1'b1;
    for (int i = 0; i < 300 && !tx_ready; i++) @(negedge clk);
    tick(1); tx_valid = 1'b0;
    tick(5);
    chk("tx2_ready_pulses", tx_rdy_cnt - snap, 1);
    chk("tx2_nwrites", count_addr(32'h14), 1);
    w = find_addr(32'h14);
    n0c = 0;
    for (int i = 0; i < w; i++) if (lg_addr[i] == 32'h0C) n0c++;
    chk("tx2_polls_before_write", n0c, 3);
    if (w >= 0) chk("tx2_wr_data", lg_data[w], 32'h5A);

    // RX pop with back-pressure
    rx_tab = '{8'h3C, 8'h7E}; rx_idx = 0; rx_stat = 32'd2; rx_ready = 1'b0;
    clr_log();
    for (int i = 0; i < 100 && !rx_valid; i++) @(negedge clk);
    chk("rx1_data", {rx_valid, rx_data}, 9'h13C);
    hold = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rx_valid && rx_data == 8'h3C) hold++;
    end
    chk("rx1_hold", hold, 5);
    chk("rx1_single_pop", count_addr(32'h18), 1);
    tick(1); rx_ready = 1'b1;
    tick(1); rx_ready = 1'b0;
    @(negedge clk);
    chk("rx1_cleared", rx_valid, 0);
    for (int i = 0; i < 100 && !rx_valid; i++) @(negedge clk);
    chk("rx2_data", {rx_valid, rx_data}, 9'h17E);
    chk("rx2_pops", count_addr(32'h18), 2);
    rx_stat = 32'd0;
    tick(1); rx_ready = 1'b1;
    tick(1); rx_ready = 1'b0;
    clr_log();
    tick(40);
    chk("rx_empty_polls_ge2", count_addr(32'h10) >= 2, 1);
    i10a = find_addr(32'h10); i10b = -1;
    for (int i = i10a + 1; i10a >= 0 && i < lg_addr.size(); i++)
      if (i10b < 0 && lg_addr[i] == 32'h10) i10b = i;
    if (i10b > 0) begin
      gap = lg_start[i10b] - lg_cyc[i10a] - 1;
      chk("rx_poll_gap_ge8", gap >= 8, 1);
    end

    // continuous TX with RX data available: services alternate
    rx_tab = '{8'h11, 8'h11}; rx_idx = 0; rx_stat = 32'd1; rx_ready = 1'b1;
    tx_tab = '{32'd0, 32'd0, 32'd0, 32'd0}; tx_idx = 0;
    tick(20);
    clr_log();
    tx_data = 8'h77; tx_valid = 1'b1;
    tick(60);
    tx_valid = 1'b0;
    alt = '{32'h0C, 32'h14, 32'h10, 32'h18, 32'h0C, 32'h14, 32'h10, 32'h18};
    k = find_addr(32'h0C);
    chk("alt_enough_xfers", (k >= 0) && (lg_addr.size() >= k + 8), 1);
    for (int i = 0; i < 8 && k >= 0 && k + i < lg_addr.size(); i++)
      chk($sformatf("alt_addr%0d", i), lg_addr[k+i], alt[i]);
    rx_stat = 32'd0;
    tick(20);

    // PSLVERR on the TX data write
    err_en = 1'b1; snap = tx_rdy_cnt;
    tx_data = 8'hC3; tx_valid = 1'b1;
    for (int i = 0; i < 100 && !err; i++) @(negedge clk);
    chk("err_set", err, 1);
    chk("err_no_tx_ready", tx_rdy_cnt - snap, 0);
    chk("err_cfg_done_low", cfg_done, 0);
    nps = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (psel) nps++;
    end
    chk("err_bus_quiet", nps, 0);
    tx_valid = 1'b0; err_en = 1'b0;

    // restart clears the error and reruns configuration
    clr_log();
    start_cfg(32'h10, 4'b1010);
    @(negedge clk);
    chk("restart_err_cleared", {err, cfg_done, busy}, 3'b001);
    wait_cfg_done(done_cyc);
    chk("restart_done", cfg_done, 1);
    check_cfg_log("cfg2", 32'h10, 32'hA);

    // async reset mid-ACCESS
    wait_cycles = 5;
    for (int i = 0; i < 50 && !(psel && penable); i++) @(negedge clk);
    chk("mid_access", {psel, penable}, 2'b11);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_psel_penable", {psel, penable, busy}, 0);
    chk("arst_status", {cfg_done, err, tx_ready, rx_valid}, 0);
    chk("arst_paddr_pstrb", {paddr[27:0], pstrb}, 0);
    tick(2);
    arst_n = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
